// File: rtl/mem_io_responder.sv
// Bus responder for the RV32 core: word RAM with byte-lane writes plus an IO page.
// IO page: LEDS register (word 0), UART TX data (word 1), UART status (word 2).
//
// Ports:
//   CLK, RESET           clock, synchronous active-high reset
//   mem_addr             byte address from the core, bits [1:0] ignored
//   mem_rstrb            read strobe; mem_rdata is registered and valid next cycle
//   mem_rdata            read data, held until the next strobe
//   mem_wdata, mem_wmask write data and byte-lane enables (any bit set = write)
//   mem_wbusy            UART_DATA write refused because a frame is in flight
//   LEDS                 LEDS register
//   TXD                  8N1 serial output, idles high
module mem_io_responder #(
    parameter int MEM_WORDS    = 256,
    parameter int IO_BIT       = 22,
    parameter int CLKS_PER_BIT = 104
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] mem_addr,
    input  logic        mem_rstrb,
    output logic [31:0] mem_rdata,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wmask,
    output logic        mem_wbusy,
    output logic [31:0] LEDS,
    output logic        TXD
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } tx_state_t;

    logic [31:0]   ram [MEM_WORDS];
    logic          is_io;
    logic          is_wr;
    logic          ram_we;
    logic          leds_we;
    logic          uart_wr;
    logic          tx_busy;
    logic          tx_accept;
    logic [AW-1:0] ram_idx;
    logic [5:0]    io_word;
    logic [31:0]   io_rdata;
    logic          unused_addr;

    tx_state_t     tx_state;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_idx;
    logic [7:0]    tx_byte;

    assign is_io       = mem_addr[IO_BIT];
    assign ram_idx     = mem_addr[AW+1:2];
    assign io_word     = mem_addr[7:2];
    assign is_wr       = |mem_wmask;
    assign unused_addr = ^mem_addr;

    // Requests seen while RESET is high are dropped.
    assign ram_we  = !RESET && !is_io && is_wr;
    assign leds_we = !RESET && is_io && is_wr && (io_word == 6'd0);
    assign uart_wr = !RESET && is_io && is_wr && (io_word == 6'd1);

    assign tx_busy   = (tx_state != S_IDLE);
    assign mem_wbusy = uart_wr && tx_busy;
    assign tx_accept = uart_wr && !tx_busy;

    always_comb begin
        io_rdata = '0;
        unique case (io_word)
            6'd0:    io_rdata = LEDS;
            6'd2:    io_rdata[9] = tx_busy;
            default: io_rdata = '0;
        endcase
    end

    // RAM is not reset; contents survive RESET.
    always_ff @(posedge CLK) begin
        if (ram_we) begin
            for (int k = 0; k < 4; k++) begin
                if (mem_wmask[k]) begin
                    ram[ram_idx][8*k +: 8] <= mem_wdata[8*k +: 8];
                end
            end
        end
    end

    // Same-edge write lands after this read, so the old word is returned.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            mem_rdata <= '0;
        end else if (mem_rstrb) begin
            mem_rdata <= is_io ? io_rdata : ram[ram_idx];
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            LEDS <= '0;
        end else if (leds_we) begin
            for (int k = 0; k < 4; k++) begin
                if (mem_wmask[k]) begin
                    LEDS[8*k +: 8] <= mem_wdata[8*k +: 8];
                end
            end
        end
    end

    // Every bit period is BIT_LAST+1 cycles; TXD is registered so it
    // changes on the same edge as the state.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_byte  <= '0;
            TXD      <= 1'b1;
        end else begin
            unique case (tx_state)
                S_IDLE: begin
                    if (tx_accept) begin
                        tx_byte  <= mem_wdata[7:0];
                        tx_cnt   <= BIT_LAST;
                        tx_state <= S_START;
                        TXD      <= 1'b0;
                    end
                end
                S_START: begin
                    if (tx_cnt == '0) begin
                        tx_cnt   <= BIT_LAST;
                        tx_idx   <= '0;
                        tx_state <= S_DATA;
                        TXD      <= tx_byte[0];
                    end else begin
                        tx_cnt <= tx_cnt - 1'b1;
                    end
                end
                S_DATA: begin
                    if (tx_cnt == '0) begin
                        tx_cnt <= BIT_LAST;
                        if (tx_idx == 3'd7) begin
                            tx_state <= S_STOP;
                            TXD      <= 1'b1;
                        end else begin
                            tx_idx <= tx_idx + 3'd1;
                            TXD    <= tx_byte[tx_idx + 3'd1];
                        end
                    end else begin
                        tx_cnt <= tx_cnt - 1'b1;
                    end
                end
                S_STOP: begin
                    if (tx_cnt == '0) begin
                        tx_state <= S_IDLE;
                    end else begin
                        tx_cnt <= tx_cnt - 1'b1;
                    end
                end
                default: begin
                    tx_state <= S_IDLE;
                    TXD      <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_io_responder.sv
// Scoreboard bench for mem_io_responder: directed cases then random traffic.
// A cycle-level reference model predicts reads, LEDS, TXD and mem_wbusy.
module tb_mem_io_responder;

    localparam int P   = 4;
    localparam int MW  = 256;
    localparam int IOB = 22;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [31:0] mem_addr = '0;
    logic        mem_rstrb = 1'b0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_wmask = '0;
    logic [31:0] mem_rdata;
    logic        mem_wbusy;
    logic [31:0] LEDS;
    logic        TXD;

    mem_io_responder #(
        .MEM_WORDS(MW),
        .IO_BIT(IOB),
        .CLKS_PER_BIT(P)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .mem_addr(mem_addr),
        .mem_rstrb(mem_rstrb),
        .mem_rdata(mem_rdata),
        .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask),
        .mem_wbusy(mem_wbusy),
        .LEDS(LEDS),
        .TXD(TXD)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_ram [MW];
    logic [31:0] m_leds = '0;
    int          m_fc = -1;   // cycle index inside the current frame, -1 when idle
    logic [7:0]  m_byte = '0;
    logic [31:0] rdq [$];
    bit          rd_due = 1'b0;
    bit          armed = 1'b0;

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] d,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++) begin
            if (m[k]) r[8*k +: 8] = d[8*k +: 8];
        end
        return r;
    endfunction

    // Frame = start bit, 8 data bits LSB first, stop bit; each P cycles.
    function automatic logic exp_txd(input int fc, input logic [7:0] b);
        int k;
        if (fc < 0) return 1'b1;
        k = fc / P;
        if (k == 0) return 1'b0;
        if (k >= 9) return 1'b1;
        return b[k-1];
    endfunction

    initial begin
        forever begin
            @(posedge CLK);
            if (RESET) begin
                m_leds = '0;
                m_fc   = -1;
                rd_due = 1'b0;
                armed  = 1'b1;
            end else begin
                bit          busy;
                bit          io;
                int unsigned word;
                int unsigned iw;
                logic [31:0] rv;
                busy = (m_fc >= 0);
                io   = mem_addr[IOB];
                word = (mem_addr >> 2) % MW;
                iw   = (mem_addr >> 2) & 63;
                rd_due = mem_rstrb;
                if (mem_rstrb) begin
                    if (!io)          rv = m_ram[word];
                    else if (iw == 0) rv = m_leds;
                    else if (iw == 2) rv = busy ? 32'h200 : 32'h0;
                    else              rv = 32'h0;
                    rdq.push_back(rv);
                end
                if (busy) begin
                    m_fc++;
                    if (m_fc == 10 * P) m_fc = -1;
                end
                if (mem_wmask != 4'h0) begin
                    if (!io) begin
                        m_ram[word] = merge(m_ram[word], mem_wdata, mem_wmask);
                    end else if (iw == 0) begin
                        m_leds = merge(m_leds, mem_wdata, mem_wmask);
                    end else if (iw == 1 && !busy) begin
                        m_byte = mem_wdata[7:0];
                        m_fc   = 0;
                    end
                end
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge CLK);
            if (armed) begin
                logic eb;
                eb = !RESET && mem_addr[IOB] && (((mem_addr >> 2) & 63) == 1)
                     && (mem_wmask != 4'h0) && (m_fc >= 0);
                if (rd_due) begin
                    if (rdq.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL rdata: got %h expected none queued", mem_rdata);
                    end else begin
                        chk("rdata", mem_rdata, rdq.pop_front());
                    end
                end
                chk("txd", 32'(TXD), 32'(exp_txd(m_fc, m_byte)));
                chk("leds", LEDS, m_leds);
                chk("wbusy", 32'(mem_wbusy), 32'(eb));
            end
        end
    end

    // ---------------- driver ----------------
    task automatic drive(input logic [31:0] a, input logic rs,
                         input logic [31:0] wd, input logic [3:0] wm);
        mem_addr  = a;
        mem_rstrb = rs;
        mem_wdata = wd;
        mem_wmask = wm;
    endtask

    task automatic cyc(input logic [31:0] a, input logic rs,
                       input logic [31:0] wd, input logic [3:0] wm);
        drive(a, rs, wd, wm);
        @(posedge CLK);
        #1;
        drive('0, 1'b0, '0, 4'h0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] m);
        cyc(a, 1'b0, d, m);
    endtask

    task automatic rd(input logic [31:0] a);
        cyc(a, 1'b1, '0, 4'h0);
    endtask

    // Holds a UART_DATA write until accepted; returns cycles spent refused.
    task automatic uart_wr(input logic [7:0] d, output int stalls);
        bit ok;
        stalls = 0;
        ok = 1'b0;
        drive(32'h0040_0004, 1'b0, {24'h0, d}, 4'hF);
        for (int i = 0; i < 12 * P + 10; i++) begin
            @(negedge CLK);
            if (!mem_wbusy) begin
                ok = 1'b1;
                break;
            end
            stalls++;
        end
        chk("uart_accept", 32'(ok), 32'd1);
        if (ok) begin
            @(posedge CLK);
            #1;
        end
        drive('0, 1'b0, '0, 4'h0);
    endtask

    initial begin
        int          st;
        logic [9:0]  pat;
        logic [31:0] a;

        RESET = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_rdata", mem_rdata, 32'h0);
        chk("rst_leds", LEDS, 32'h0);
        chk("rst_txd", 32'(TXD), 32'd1);
        chk("rst_wbusy", 32'(mem_wbusy), 32'd0);
        RESET = 1'b0;

        for (int i = 0; i < MW; i++) wr(32'(i * 4), $urandom, 4'hF);

        wr(32'h10, 32'hDEAD_BEEF, 4'hF);
        rd(32'h10);
        chk("rd_full", mem_rdata, 32'hDEAD_BEEF);
        wr(32'h10, 32'h0000_00AA, 4'h1);
        rd(32'h10);
        chk("rd_lane0", mem_rdata, 32'hDEAD_BEAA);

        wr(32'h400, 32'h1234_5678, 4'hF);
        rd(32'h000);
        chk("rd_wrap", mem_rdata, 32'h1234_5678);

        wr(32'h20, 32'h7, 4'hF);
        cyc(32'h20, 1'b1, 32'h1, 4'hF);
        chk("rd_before_wr", mem_rdata, 32'h7);
        rd(32'h20);
        chk("rd_after_wr", mem_rdata, 32'h1);

        wr(32'h0040_0000, 32'h0000_F00D, 4'hF);
        chk("leds_wr", LEDS, 32'h0000_F00D);
        rd(32'h0040_0000);
        chk("leds_rd", mem_rdata, 32'h0000_F00D);

        uart_wr(8'h55, st);
        chk("uart_first_nostall", 32'(st), 32'd0);
        pat = {1'b1, 8'h55, 1'b0};
        for (int i = 0; i < 10 * P; i++) begin
            @(negedge CLK);
            chk("uart55_bit", 32'(TXD), 32'(pat[i / P]));
        end
        @(negedge CLK);
        chk("uart55_idle", 32'(TXD), 32'd1);
        rd(32'h0040_0008);
        chk("stat_idle", mem_rdata, 32'h0);

        uart_wr(8'h41, st);
        uart_wr(8'h42, st);
        chk("wbusy_cycles", 32'(st), 32'(10 * P));
        repeat (3 * P) @(posedge CLK);
        #1;
        chk("txd_pre_rst", 32'(TXD), 32'd0);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        chk("midframe_rst_txd", 32'(TXD), 32'd1);
        chk("midframe_rst_leds", LEDS, 32'h0);
        rd(32'h0040_0008);
        chk("midframe_rst_busy", mem_rdata, 32'h0);

        for (int i = 0; i < 3000; i++) begin
            a = $urandom;
            if ($urandom_range(0, 99) < 50) begin
                a[IOB] = 1'b0;
            end else begin
                a[IOB] = 1'b1;
                case ($urandom_range(0, 3))
                    0: a[7:2] = 6'd0;
                    1: a[7:2] = 6'd1;
                    2: a[7:2] = 6'd2;
                    default: a[7:2] = 6'($urandom);
                endcase
            end
            drive(a, 1'($urandom_range(0, 1)), $urandom,
                  ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom));
            RESET = ($urandom_range(0, 299) == 0);
            @(posedge CLK);
            #1;
            RESET = 1'b0;
        end
        drive('0, 1'b0, '0, 4'h0);
        repeat (4) @(posedge CLK);
        @(negedge CLK);
        chk("rdq_empty", 32'(rdq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
- Bus responder for the RV32 core's memory interface. The core is the initiator; this block is the other end.
- Serves word-addressed RAM with byte-lane writes and a small memory-mapped IO page.
- IO page holds a LEDS register and an 8N1 UART transmitter driving TXD.
- Sits in SOC between the core and the board pins; replaces the tied-off TXD.

Parameters:
- MEM_WORDS, 256: RAM depth in 32-bit words; power of two.
- IO_BIT, 22: address bit that selects IO space when set.
- CLKS_PER_BIT, 104: clk cycles per UART bit; must be ≥2.

Ports:
- CLK  in  1  clock.
- RESET  in  1  reset.
- mem_addr  in  32  byte address; bits [1:0] ignored.
- mem_rstrb  in  1  read strobe, one cycle per read.
- mem_rdata  out  32  read data.
- mem_wdata  in  32  write data.
- mem_wmask  in  4  byte-lane write enables; any bit set means write.
- mem_wbusy  out  1  write not accepted this cycle; initiator holds the request.
- LEDS  out  32  LEDS register.
- TXD  out  1  UART serial out; idles high.

Behaviour:
- One clock (CLK); RESET is synchronous and active-high.
- Reset values: mem_rdata=0, LEDS=0, TXD=1, UART state IDLE, mem_wbusy=0. RAM contents are not cleared.
- Decode: mem_addr[IO_BIT]=0 selects RAM at word index mem_addr[log2(MEM_WORDS)+1:2]. Out-of-range addresses wrap modulo MEM_WORDS.
- Decode: mem_addr[IO_BIT]=1 selects IO word mem_addr[7:2]:
  - 0: LEDS (R/W).
  - 1: UART_DATA (W only; reads return 0).
  - 2: UART_STAT (R only; bit9=busy, other bits 0).
  - All other IO words: reads return 0, writes ignored.
- Read: mem_rstrb in cycle N → mem_rdata valid in cycle N+1 (registered). mem_rdata holds its value until the next strobe. No read stall.
- Write, RAM and LEDS: each byte lane k with mem_wmask[k]=1 updates bits [8k+7:8k] at the end of cycle N. Other lanes are unchanged.
- Simultaneous read and write, same address: read-before-write; mem_rdata returns the old value.
- Write to UART_DATA (any mask bit set):
  - Accepted when the TX state is IDLE.
  - mem_wdata[7:0] is latched and the TX goes to START next cycle.
  - mem_wbusy is combinational: it is 1 when an IO write to UART_DATA is presented while TX is not IDLE. That write is ignored, and the initiator retries until mem_wbusy=0.
  - mem_wbusy is 0 for all other accesses.
- UART TX FSM: IDLE → START → DATA → STOP → IDLE.
  - START drives TXD=0.
  - DATA drives 8 bits, LSB first.
  - STOP drives TXD=1.
  - Each bit lasts exactly CLKS_PER_BIT cycles, timed by a down-counter.
  - A 3-bit index counts the DATA bits.
- UART timing:
  - TXD falls on the cycle after the accepting edge.
  - Frame length is 10*CLKS_PER_BIT cycles; IDLE is re-entered on its last edge.
  - A new write is accepted in the first IDLE cycle, so back-to-back frames have no idle gap.
- busy (UART_STAT bit9) = (state != IDLE). Reading UART_STAT in the acceptance cycle returns the pre-edge value 0.
- Reset mid-frame aborts the frame: TXD=1 and IDLE on the next cycle. The latched byte is discarded.
- Reset takes priority over simultaneous bus requests; requests presented during reset are dropped.

Test Plan:
- Write 0xDEADBEEF to 0x10, mask 1111; then rstrb 0x10 → mem_rdata=0xDEADBEEF one cycle after the strobe. Then write 0x000000AA, mask 0001 → readback 0xDEADBEAA.
- Wrap: with MEM_WORDS=256, write 0x12345678 to 0x400; rstrb 0x000 → 0x12345678.
- Read-before-write: rstrb and a write of 0x1 to 0x20 (old value 0x7) in the same cycle → mem_rdata=0x7; next read of 0x20 → 0x1.
- LEDS: write 0x0000F00D to 0x400000 (IO_BIT=22) → LEDS=0x0000F00D next cycle; rstrb 0x400000 → 0x0000F00D.
- UART, CLKS_PER_BIT=4: write 0x55 to 0x400004 → TXD pattern 0,1,0,1,0,1,0,1,0,1, each held 4 cycles (40 cycles total), then high. UART_STAT bit9=1 throughout the frame, 0 after.
- Back-pressure and reset: write 0x41 to UART_DATA, then immediately write 0x42 → mem_wbusy=1 until the first frame ends. The second frame must then start with no gap. Assert RESET in bit 3 of the second frame → TXD=1 the next cycle, busy=0, LEDS=0.
